// File: rtl/sr04_dist_filter.sv
// rtl/sr04_dist_filter.sv - range gate, 4-tap moving average and sequential BCD converter for SR04 distances
module sr04_dist_filter #(
  parameter int MIN_CM = 2,
  parameter int MAX_CM = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dist_done,
  input  logic [9:0]  distance,
  output logic [9:0]  avg_dist,
  output logic        avg_valid,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic        out_of_range,
  output logic        busy
);

  localparam logic [9:0] MIN_V = 10'(MIN_CM);
  localparam logic [9:0] MAX_V = 10'(MAX_CM);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  logic [9:0]  ent_q [4];
  logic [1:0]  ptr_q;
  logic        filled_q;
  logic [11:0] sum_q;
  logic        upd_q;
  logic        oor_q;
  logic [9:0]  avg_q;
  logic        avg_valid_q;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [9:0]  bin_q;
  logic [15:0] scr_q;
  logic [9:0]  pend_q;
  logic        pend_v_q;
  logic [15:0] bcd_q;
  logic        bcd_valid_q;

  logic        sample_ok;
  logic [9:0]  new_avg;
  logic [15:0] scr_adj;

  // Add 3 to every BCD digit of 5 or more before the doubling shift.
  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign sample_ok = (distance >= MIN_V) && (distance <= MAX_V);
  assign new_avg   = sum_q[11:2];
  assign scr_adj   = add3(scr_q);

  // Range gate and circular buffer with running sum; first accepted sample prefills all taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) ent_q[i] <= '0;
      ptr_q    <= '0;
      filled_q <= 1'b0;
      sum_q    <= '0;
      upd_q    <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (dist_done) begin
        if (!sample_ok) begin
          oor_q <= 1'b1;
        end else begin
          oor_q <= 1'b0;
          upd_q <= 1'b1;
          if (!filled_q) begin
            for (int i = 0; i < 4; i++) ent_q[i] <= distance;
            sum_q    <= {distance, 2'b00};
            filled_q <= 1'b1;
            ptr_q    <= '0;
          end else begin
            sum_q        <= sum_q - {2'b00, ent_q[ptr_q]} + {2'b00, distance};
            ent_q[ptr_q] <= distance;
            ptr_q        <= ptr_q + 2'd1;
          end
        end
      end
    end
  end

  // Register the truncated average one cycle after the sum settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= upd_q;
      if (upd_q) avg_q <= new_avg;
    end
  end

  // Double-dabble converter; a newer average arriving while busy replaces any pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      scr_q       <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (upd_q) begin
            bin_q   <= new_avg;
            scr_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scr_q <= {scr_adj[14:0], bin_q[9]};
          bin_q <= {bin_q[8:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) state_q <= S_DONE;
          if (upd_q) begin
            pend_q   <= new_avg;
            pend_v_q <= 1'b1;
          end
        end
        S_DONE: begin
          bcd_q       <= scr_q;
          bcd_valid_q <= 1'b1;
          scr_q       <= '0;
          cnt_q       <= '0;
          if (upd_q) begin
            bin_q    <= new_avg;
            pend_v_q <= 1'b0;
            state_q  <= S_SHIFT;
          end else if (pend_v_q) begin
            bin_q    <= pend_q;
            pend_v_q <= 1'b0;
            state_q  <= S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign avg_dist     = avg_q;
  assign avg_valid    = avg_valid_q;
  assign bcd          = bcd_q;
  assign bcd_valid    = bcd_valid_q;
  assign out_of_range = oor_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sr04_dist_filter.sv
// tb/tb_sr04_dist_filter.sv - scoreboard bench for sr04_dist_filter
module tb_sr04_dist_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dist_done = 1'b0, dist_done2 = 1'b0;
  logic [9:0]  distance = '0, distance2 = '0;
  logic [9:0]  avg_dist, avg_dist2;
  logic        avg_valid, avg_valid2;
  logic [15:0] bcd, bcd2;
  logic        bcd_valid, bcd_valid2;
  logic        out_of_range, out_of_range2;
  logic        busy, busy2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_avg_cyc = 0;
  int last_bcd_cyc = 0;
  int e0 = 0;

  logic [9:0]  qa1 [$];
  logic [15:0] qb1 [$];
  logic [9:0]  qa2 [$];
  logic [15:0] qb2 [$];

  sr04_dist_filter u_dut (
    .clk(clk), .rst(rst), .dist_done(dist_done), .distance(distance),
    .avg_dist(avg_dist), .avg_valid(avg_valid), .bcd(bcd), .bcd_valid(bcd_valid),
    .out_of_range(out_of_range), .busy(busy)
  );

  sr04_dist_filter #(.MIN_CM(1), .MAX_CM(1023)) u_dut_full (
    .clk(clk), .rst(rst), .dist_done(dist_done2), .distance(distance2),
    .avg_dist(avg_dist2), .avg_valid(avg_valid2), .bcd(bcd2), .bcd_valid(bcd_valid2),
    .out_of_range(out_of_range2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=pulse required=none", name);
  endtask

  // Monitor: pop expected values whenever a DUT presents a valid output.
  always @(negedge clk) begin
    if (avg_valid) begin
      last_avg_cyc = cyc;
      if (qa1.size() == 0) unexpected("avg_valid");
      else chk("avg_dist", 32'(avg_dist), 32'(qa1.pop_front()));
    end
    if (bcd_valid) begin
      last_bcd_cyc = cyc;
      if (qb1.size() == 0) unexpected("bcd_valid");
      else chk("bcd", 32'(bcd), 32'(qb1.pop_front()));
    end
    if (avg_valid2) begin
      if (qa2.size() == 0) unexpected("avg_valid_full");
      else chk("avg_dist_full", 32'(avg_dist2), 32'(qa2.pop_front()));
    end
    if (bcd_valid2) begin
      if (qb2.size() == 0) unexpected("bcd_valid_full");
      else chk("bcd_full", 32'(bcd2), 32'(qb2.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] d);
    dist_done = 1'b1;
    distance  = d;
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    dist_done = 1'b0;
  endtask

  task automatic send2(input logic [9:0] d);
    dist_done2 = 1'b1;
    distance2  = d;
    @(posedge clk);
    #1;
    dist_done2 = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_avg_dist"}, 32'(avg_dist), 32'd0);
    chk({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd), 32'd0);
    chk({tag, "_bcd_valid"}, 32'(bcd_valid), 32'd0);
    chk({tag, "_oor"}, 32'(out_of_range), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    chk_zero("reset");
    rst = 1'b0;
    idle(1);

    // Prefill with latency checks
    qa1.push_back(10'd100); qb1.push_back(16'h0100);
    send(10'd100);
    idle(14);
    chk("prefill_avg_latency", 32'(last_avg_cyc - e0), 32'd1);
    chk("prefill_bcd_latency", 32'(last_bcd_cyc - last_avg_cyc), 32'd11);
    chk("prefill_busy_after", 32'(busy), 32'd0);

    // Window slide
    qa1.push_back(10'd101); qb1.push_back(16'h0101); send(10'd104); idle(13);
    qa1.push_back(10'd103); qb1.push_back(16'h0103); send(10'd108); idle(13);
    qa1.push_back(10'd106); qb1.push_back(16'h0106); send(10'd112); idle(13);
    qa1.push_back(10'd110); qb1.push_back(16'h0110); send(10'd116); idle(13);

    // Range reject, then an accepted sample
    send(10'd500);
    chk("oor_high", 32'(out_of_range), 32'd1);
    idle(2);
    send(10'd1);
    chk("oor_low", 32'(out_of_range), 32'd1);
    idle(2);
    qa1.push_back(10'd134); qb1.push_back(16'h0134);
    send(10'd200);
    chk("oor_clear", 32'(out_of_range), 32'd0);
    idle(3);
    chk("busy_mid", 32'(busy), 32'd1);
    idle(11);
    chk("busy_end", 32'(busy), 32'd0);

    // Pending collapse: only first and latest averages convert
    qa1.push_back(10'd137); qa1.push_back(10'd140); qa1.push_back(10'd143);
    qb1.push_back(16'h0137); qb1.push_back(16'h0143);
    send(10'd120); idle(2);
    send(10'd124); idle(2);
    send(10'd128);
    idle(30);
    chk("pending_busy_end", 32'(busy), 32'd0);

    // Reset mid-conversion
    qa1.push_back(10'd108);
    send(10'd60);
    idle(5);
    rst = 1'b1;
    idle(1);
    chk_zero("midreset");
    rst = 1'b0;
    idle(15);
    qa1.push_back(10'd50); qb1.push_back(16'h0050);
    send(10'd50);
    idle(14);

    // Full-range instance: truncation and full-scale BCD
    qa2.push_back(10'd1); qb2.push_back(16'h0001);
    send2(10'd1); idle(13);
    qa2.push_back(10'd1); qb2.push_back(16'h0001);
    send2(10'd2); idle(13);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    qa2.push_back(10'd1023); qb2.push_back(16'h1023);
    send2(10'd1023); idle(14);
    chk("full_oor", 32'(out_of_range2), 32'd0);

    chk("qa1_drained", 32'(qa1.size()), 32'd0);
    chk("qb1_drained", 32'(qb1.size()), 32'd0);
    chk("qa2_drained", 32'(qa2.size()), 32'd0);
    chk("qb2_drained", 32'(qb2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr04_dist_filter.md
# sr04_dist_filter

Downstream stage of the SR04 ultrasonic controller. Consumes each raw 10-bit distance (cm) and its one-cycle done strobe, rejects out-of-range readings, and smooths accepted samples with a 4-tap moving average. Converts the averaged value to 4-digit packed BCD with a sequential double-dabble engine, so the result can drive the watch FND display path directly.

## Interface
Parameters:
- MIN_CM, 2: smallest accepted raw distance (inclusive).
- MAX_CM, 400: largest accepted raw distance (inclusive); legal range 0..1023.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  reset, synchronous and active-high.
- dist_done  in  1  one-cycle strobe: `distance` is valid this cycle.
- distance  in  10  raw distance, cm.
- avg_dist  out  10  averaged distance, cm.
- avg_valid  out  1  one-cycle pulse when `avg_dist` updates.
- bcd  out  16  packed BCD of the last converted `avg_dist`: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- bcd_valid  out  1  one-cycle pulse when `bcd` updates.
- out_of_range  out  1  level; 1 if the most recent sample was rejected.
- busy  out  1  BCD converter is running.

## Operation
- **Sample accept.** At a clock edge with dist_done=1, the sample is valid iff MIN_CM ≤ distance ≤ MAX_CM.
  - Invalid: out_of_range←1; buffer, sum and outputs otherwise unchanged; no avg_valid.
  - Valid: out_of_range←0; buffer updates as below.
- **Buffer.** 4-entry circular buffer, 2-bit write pointer, `filled` flag, 12-bit running sum (max 4×1023 = 4092, no overflow).
  - First valid sample after reset (filled=0): all 4 entries ← d; sum ← 4·d; filled←1; ptr←0.
  - Later samples: sum ← sum − buf[ptr] + d; buf[ptr] ← d; ptr ← ptr+1, wrapping 3→0.
- **Average.** Computed as avg_dist = sum[11:2], i.e. truncating divide by 4.
- **Converter FSM: IDLE → SHIFT → DONE → IDLE.**
  - IDLE: on avg_valid, load avg_dist and clear the BCD scratch; go to SHIFT.
  - SHIFT: exactly 10 iterations, one per clock. Each iteration applies add-3 to every nibble ≥5, then shifts left one bit.
  - DONE: register bcd and pulse bcd_valid. If a pending value exists, load it and return to SHIFT at the next edge; otherwise go to IDLE.
- **busy.** busy=1 in SHIFT and DONE.
- **Pending.** avg_valid while busy stores avg_dist into a one-deep pending register. A newer value overwrites an older unserviced one, so only the latest is converted.
- **Back-to-back strobes.** dist_done on consecutive cycles gives independent samples; each valid one yields its own avg_valid.

## Timing
- **Reset values.** All outputs 0 after reset: avg_dist, avg_valid, bcd, bcd_valid, out_of_range, busy. Buffer, sum, ptr, filled, pending and FSM (→IDLE) also clear.
- **Reset mid-operation.** rst wins over every other input in the same cycle. A conversion in flight is abandoned and gives no bcd_valid. The next valid sample is treated as the first one (prefill).
- **Latency.** Let E0 be the edge sampling a valid dist_done.
  - E0: buffer and sum update.
  - E1: avg_dist registered, avg_valid high for the cycle after E1. If the FSM is IDLE, the converter also loads at E1.
  - E2..E11: the ten shift iterations.
  - E12: bcd and bcd_valid update.
  - bcd_valid therefore rises 11 cycles after avg_valid and 12 after E0.
- **Busy window.** busy rises after E1 and falls after E12, unless pending restarts the converter.
- **Throughput.** The filter accepts 1 sample/cycle. The converter finishes one value per 12 cycles; excess values collapse into pending.

## Test plan
- **Prefill.** After reset, distance=100 with dist_done → avg_dist=100 with avg_valid 2 edges after the strobe; bcd=0x0100 with bcd_valid 11 cycles after avg_valid.
- **Window slide.** After prefill at 100, valid samples 104, 108, 112 → avg_dist 101, 103, 106. Then 116 → 110, once all four prefill entries are evicted.
- **Range reject.** Inject 500 (with MAX_CM=400) → out_of_range=1, no avg_valid, sum unchanged. Then inject 1 (with MIN_CM=2) → still 1. Then inject 200 → out_of_range=0 and the average updates.
- **Truncation and full-scale BCD.** MAX_CM=1023. Prefill 1, then add 2 → avg_dist=1 (sum 5). Separately, prefill 1023 → bcd=0x1023.
- **Pending.** Valid samples 3 cycles apart while busy → first conversion completes, then the latest pending value is converted immediately. Exactly two bcd_valid pulses occur, the second carrying the last average.
- **Reset mid-conversion.** Assert rst at E6 → all outputs 0 and no bcd_valid. The next sample of 50 yields avg_dist=50, confirming prefill re-occurs.
